// File: rtl/kwan_cpu_pkg.sv
// Shared definitions for the 8-bit computer: default widths, dump sequencer
// states and the opcode constants used by the benches.
package kwan_cpu_pkg;

  localparam int WORD_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  localparam logic [7:0] LDA = 8'h10;
  localparam logic [7:0] ADD = 8'h20;
  localparam logic [7:0] SUB = 8'h30;
  localparam logic [7:0] OUT = 8'he0;
  localparam logic [7:0] HLT = 8'hf0;

endpackage

// File: rtl/wrap_addr_counter.sv
// Dump address pointer: loads the first address, counts up mod 2^A and
// flags when it has reached the captured last address.
module wrap_addr_counter
  import kwan_cpu_pkg::*;
#(
  parameter int A = ADDR_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [A-1:0] first,
  input  logic [A-1:0] last,
  input  logic         inc,
  output logic [A-1:0] ptr,
  output logic         at_last
);

  logic [A-1:0] last_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr    <= '0;
      last_q <= '0;
    end else if (load) begin
      ptr    <= first;
      last_q <= last;
    end else if (inc) begin
      ptr    <= ptr + 1'b1;
    end
  end

  assign at_last = (ptr == last_q);

endmodule

// File: rtl/mem_dump_reader.sv
// Program RAM read-back sequencer: streams (address, data) pairs over an
// inclusive, wrapping range. Define MEM_DUMP_CHECKSUM_EN to build the checksum.
module mem_dump_reader
  import kwan_cpu_pkg::*;
#(
  parameter int N = WORD_W,
  parameter int A = ADDR_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         abort,
  input  logic [A-1:0] first_addr,
  input  logic [A-1:0] last_addr,
  input  logic [N-1:0] memval,
  output logic [A-1:0] dump_addr,
  output logic         dump_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [A-1:0] out_addr,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] checksum
);

  dump_state_t  state_q, state_d;
  logic         load, accept, at_last;
  logic [A-1:0] ptr;

  wrap_addr_counter #(.A(A)) u_ptr (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .first   (first_addr),
    .last    (last_addr),
    .inc     (accept && !at_last),
    .ptr     (ptr),
    .at_last (at_last)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = ADDR;
      end
      ADDR: state_d = abort ? IDLE : SEND;
      SEND: begin
        // Abort beats a simultaneous handshake: the pending word is dropped.
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          accept  = 1'b1;
          state_d = at_last ? DONE : ADDR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM read is combinational, so memval has settled by the end of ADDR.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_addr <= '0;
      out_data <= '0;
    end else if (state_q == ADDR) begin
      out_addr <= ptr;
      out_data <= memval;
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [N-1:0] sum_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)         sum_q <= '0;
    else if (load)   sum_q <= '0;
    else if (accept) sum_q <= sum_q + out_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign dump_addr = ptr;
  assign busy      = (state_q != IDLE);
  assign dump_sel  = busy;
  assign out_valid = (state_q == SEND);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: table of dump ranges plus
// hand-written reset, clr, abort and start/abort corner sequences.
module tb_mem_dump_reader;

  logic       clk = 1'b0;
  logic       clr;
  logic       start, abort, out_ready;
  logic [3:0] first_addr, last_addr;
  logic [7:0] memval;
  logic [3:0] dump_addr, out_addr;
  logic       dump_sel, out_valid, busy, done;
  logic [7:0] out_data, checksum;

  logic [7:0] ram [16];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] first;
    logic [3:0] last;
    logic [3:0] stall_addr;
    int         stall_n;
    bit         poke_start;
    int         count;
    logic [7:0] sum;
    int         done_cyc;
  } dump_vec_t;

  dump_vec_t tbl [6];

  always #5 clk = ~clk;

  assign memval = ram[dump_addr];

  mem_dump_reader #(.N(8), .A(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .memval     (memval),
    .dump_addr  (dump_addr),
    .dump_sel   (dump_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ck_exp(input logic [7:0] sum);
`ifdef MEM_DUMP_CHECKSUM_EN
    return sum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " dump_addr"}, 32'(dump_addr), 0);
    check({tag, " dump_sel"},  32'(dump_sel),  0);
    check({tag, " out_valid"}, 32'(out_valid), 0);
    check({tag, " out_addr"},  32'(out_addr),  0);
    check({tag, " out_data"},  32'(out_data),  0);
    check({tag, " busy"},      32'(busy),      0);
    check({tag, " done"},      32'(done),      0);
    check({tag, " checksum"},  32'(checksum),  0);
  endtask

  task automatic run_dump(input dump_vec_t v, input int idx);
    int         words   = 0;
    int         stalled = 0;
    bit         got_done = 0;
    logic [3:0] exp_a;
    @(negedge clk);
    first_addr = v.first;
    last_addr  = v.last;
    out_ready  = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = (v.poke_start && c == 3);
      check($sformatf("v%0d busy c%0d", idx, c), 32'(busy), 1);
      if (out_valid && v.stall_n > 0 && out_addr == v.stall_addr && stalled < v.stall_n) begin
        out_ready = 1'b0;
        stalled++;
        check($sformatf("v%0d stall data", idx), 32'(out_data), 32'(ram[v.stall_addr]));
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        exp_a = v.first + 4'(words);
        check($sformatf("v%0d w%0d addr", idx, words), 32'(out_addr), 32'(exp_a));
        check($sformatf("v%0d w%0d data", idx, words), 32'(out_data), 32'(ram[exp_a]));
        words++;
      end
      if (done) begin
        check($sformatf("v%0d done cycle", idx), c, v.done_cyc);
        got_done = 1;
        break;
      end
    end
    start = 1'b0;
    check($sformatf("v%0d got done", idx), 32'(got_done), 1);
    check($sformatf("v%0d word count", idx), words, v.count);
    @(negedge clk);
    check($sformatf("v%0d idle busy", idx), 32'(busy), 0);
    check($sformatf("v%0d done pulse", idx), 32'(done), 0);
    check($sformatf("v%0d checksum", idx), 32'(checksum), 32'(ck_exp(v.sum)));
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0] = 8'h1E; ram[1] = 8'h2F; ram[2] = 8'hE0; ram[5] = 8'h5A; ram[15] = 8'hAA;

    //        first  last   stall  n  poke cnt sum    done
    tbl[0] = '{4'h0, 4'h2, 4'h0, 0, 0,  3, 8'h2D,  7};
    tbl[1] = '{4'hF, 4'h1, 4'h0, 0, 0,  3, 8'hF7,  7};
    tbl[2] = '{4'h5, 4'h5, 4'h0, 0, 0,  1, 8'h5A,  3};
    tbl[3] = '{4'h3, 4'h2, 4'h0, 0, 0, 16, 8'h31, 33};
    tbl[4] = '{4'h0, 4'h2, 4'h1, 5, 0,  3, 8'h2D, 12};
    tbl[5] = '{4'hF, 4'h1, 4'h0, 0, 1,  3, 8'hF7,  7};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    clr = 1'b0;

    for (int i = 0; i < 6; i++) run_dump(tbl[i], i);

    // clr while in SEND: outputs drop at once and the dump does not resume.
    @(negedge clk);
    first_addr = 4'h0; last_addr = 4'h2; out_ready = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("clr pre out_valid", 32'(out_valid), 1);
    clr = 1'b1;
    #1;
    check_all_zero("clr async");
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("clr no resume", 32'(busy), 0);
    run_dump(tbl[0], 10);

    // abort in ADDR of word 1.
    @(negedge clk);
    first_addr = 4'h0; last_addr = 4'h2; out_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort in ADDR busy", 32'(busy), 1);
    check("abort in ADDR valid", 32'(out_valid), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort idle busy", 32'(busy), 0);
    check("abort idle valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      check("abort no done", 32'(done), 0);
      @(negedge clk);
    end

    // start and abort together in IDLE: start wins.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start wins busy", 32'(busy), 1);
    @(negedge clk);
    abort = 1'b0;
    check("start wins abort", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
